// File: rtl/sw_input_port.sv
// Debounced switch input port with sticky rise/fall flags, event counter and CPU read interface.
// Optional macro SW_IRQ_EN enables a registered interrupt (OR of all pending flags); otherwise irq is tied low.
module sw_input_port #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             rd_req,
  input  logic [1:0]       rd_addr,
  output logic             rd_ack,
  output logic [31:0]      rd_data,
  output logic             irq
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; the flip happens on the next differing edge.
  localparam int unsigned    CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise_flags;
  logic [WIDTH-1:0] fall_flags;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic [CW-1:0]    cnt [WIDTH];
  logic [31:0]      event_cnt;
  logic [31:0]      flip_count;
  logic [31:0]      rd_mux;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    flip       = '0;
    flip_count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      flip[i]    = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
      flip_count = flip_count + 32'(flip[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable <= stable ^ flip;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i] || flip[i]) cnt[i] <= '0;
        else                                   cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = rise_flags;
      2'd2:    rd_mux[WIDTH-1:0] = fall_flags;
      default: rd_mux            = event_cnt;
    endcase
  end

  assign rise_clr = (rd_req && rd_addr == 2'd1) ? '1 : '0;
  assign fall_clr = (rd_req && rd_addr == 2'd2) ? '1 : '0;

  // Clearing applies to old flags only, so an edge landing on the read-clear edge stays pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_flags <= '0;
      fall_flags <= '0;
      event_cnt  <= '0;
      rd_ack     <= 1'b0;
      rd_data    <= '0;
    end else begin
      rise_flags <= (rise_flags & ~rise_clr) | (flip & ~stable);
      fall_flags <= (fall_flags & ~fall_clr) | (flip & stable);
      event_cnt  <= event_cnt + flip_count;
      rd_ack     <= rd_req;
      rd_data    <= rd_req ? rd_mux : '0;
    end
  end

`ifdef SW_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) irq <= 1'b0;
    else        irq <= |{rise_flags, fall_flags};
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: doc/sw_input_port.md
SW_INPUT_PORT -- requirements
Module: sw_input_port

Interface
REQ-001 Parameter: WIDTH, default 16, number of switch inputs (1..32).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 16, consecutive stable synchronized cycles required to accept a change (>=1).
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: sw_raw  input  WIDTH  asynchronous switch levels.
REQ-006 Port: rd_req  input  1  CPU read request, one request per cycle it is high.
REQ-007 Port: rd_addr  input  2  register select, sampled with rd_req.
REQ-008 Port: rd_ack  output  1  read response valid.
REQ-009 Port: rd_data  output  32  read response data.
REQ-010 Port: irq  output  1  pending-event interrupt.

Function
REQ-011 Each sw_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each bit SHALL keep a debounce counter and a stable state: counter clears when synced == stable, increments when synced != stable.
REQ-013 When synced has differed from stable for DEBOUNCE_CYCLES consecutive cycles, stable SHALL flip on that edge and the counter SHALL clear.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change stable.
REQ-015 Latency from sw_raw change (held) to stable change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-016 A stable 0->1 flip SHALL set that bit's rise flag; a 1->0 flip SHALL set that bit's fall flag; flags are sticky.
REQ-017 Each stable flip SHALL increment a 32-bit event counter by one per flipped bit in that cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-018 Register map: addr 0 = stable state, addr 1 = rise flags, addr 2 = fall flags, addr 3 = event counter; fields narrower than 32 bits zero-extended.
REQ-019 A request accepted on cycle N SHALL produce rd_ack=1 and rd_data on cycle N+1; rd_ack SHALL be 0 otherwise; back-to-back requests SHALL each be acknowledged on consecutive cycles.
REQ-020 rd_data SHALL be 0 whenever rd_ack is 0.
REQ-021 Reading addr 1 or 2 SHALL return the flags as held before the accepting edge and clear them on that edge (read-to-clear).
REQ-022 If a new edge sets a flag on the same edge it is cleared by a read, the new flag SHALL remain set and SHALL NOT appear in that read's data.
REQ-023 Reads of addr 0 and 3 SHALL have no side effects.

Reset
REQ-024 While reset=0 at a clock edge: synchronizers, stable state, counters, flags and event counter SHALL be 0; rd_ack=0, rd_data=0, irq=0.
REQ-025 A read pending when reset asserts SHALL be dropped (no rd_ack after reset).
REQ-026 After reset release, switches already high SHALL be reported as a rise after the REQ-015 latency.

Configuration
REQ-027 Macro SW_IRQ_EN: when defined, irq SHALL be a register equal to the OR of all rise and fall flags, updated one cycle after the flags change.
REQ-028 When SW_IRQ_EN is not defined, the irq port SHALL exist and be driven constant 0; all other behaviour unchanged.

Verification (WIDTH=16, DEBOUNCE_CYCLES=4)
REQ-029 Reset with sw_raw=0x0000, raise bit 3 and hold -> stable changes exactly 6 cycles later; read addr 0 -> 0x0000_0008; addr 1 -> 0x0000_0008; second addr 1 read -> 0x0000_0000.
REQ-030 Pulse bit 5 high for 3 synchronized cycles -> addr 0 stays 0x0000_0000, addr 3 unchanged, no flags set.
REQ-031 Bit 3 falls while an addr 2 read is accepted on the flip edge -> that read returns 0x0000_0000; next addr 2 read returns 0x0000_0008.
REQ-032 rd_req held high 4 cycles with addr 0,1,2,3 -> rd_ack high for exactly 4 consecutive cycles, one cycle delayed, data in order.
REQ-033 Preload the event counter to 0xFFFF_FFFF via 0xFFFF_FFFF flips (or force), flip two bits in one cycle -> addr 3 reads 0x0000_0001.
REQ-034 With SW_IRQ_EN: rise on bit 0 -> irq=1 one cycle after flag set; reads clearing addr 1 -> irq=0 one cycle later; without macro irq stays 0 throughout.
